// File: rtl/div_scan_ctrl.sv
// ============================================================================
// Module   : div_scan_ctrl
// Purpose  : Scan/single-check sequencer for the even / divisible-by-3 LEDs,
//            with per-value hold timer and running hit counters.
// Option   : DIV_SCAN_PAUSE_EN adds a pause input that freezes the hold timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_scan_ctrl #(
   parameter int HOLD_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       mode,
   input  logic [3:0] sw,
`ifdef DIV_SCAN_PAUSE_EN
   input  logic       pause,
`endif
   output logic [3:0] val,
   output logic       led1,
   output logic       led2,
   output logic       busy,
   output logic       done,
   output logic [3:0] even_cnt,
   output logic [3:0] div3_cnt
);

   localparam int            c_TW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [c_TW-1:0] c_LAST = c_TW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SHOW = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic logic f_even(input logic [3:0] v);
      return (v[0] == 1'b0) && (v != 4'd0);
   endfunction

   function automatic logic f_div3(input logic [3:0] v);
      return ((v % 4'd3) == 4'd0) && (v != 4'd0);
   endfunction

   state_t          r_state;
   logic [c_TW-1:0] r_timer;
   logic            r_mode;
   logic [3:0]      r_val;
   logic            r_led1;
   logic            r_led2;
   logic            r_busy;
   logic            r_done;
   logic [3:0]      r_even_cnt;
   logic [3:0]      r_div3_cnt;

   logic            w_pause;
   logic [3:0]      w_load;
   logic [3:0]      w_next;

`ifdef DIV_SCAN_PAUSE_EN
   assign w_pause = pause;
`else
   assign w_pause = 1'b0;
`endif

   assign w_load = mode ? 4'd1 : sw;
   assign w_next = r_val + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_timer    <= '0;
         r_mode     <= 1'b0;
         r_val      <= 4'd0;
         r_led1     <= 1'b0;
         r_led2     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_even_cnt <= 4'd0;
         r_div3_cnt <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_val      <= w_load;
                  r_led1     <= f_even(w_load);
                  r_led2     <= f_div3(w_load);
                  r_even_cnt <= {3'b000, f_even(w_load)};
                  r_div3_cnt <= {3'b000, f_div3(w_load)};
                  r_mode     <= mode;
                  r_timer    <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= S_SHOW;
               end
            end
            S_SHOW: begin
               // A paused cycle leaves every piece of visible state untouched.
               if (!w_pause) begin
                  if (r_timer == c_LAST) begin
                     r_timer <= '0;
                     if (r_mode && (r_val != 4'd15)) begin
                        r_val      <= w_next;
                        r_led1     <= f_even(w_next);
                        r_led2     <= f_div3(w_next);
                        r_even_cnt <= r_even_cnt + {3'b000, f_even(w_next)};
                        r_div3_cnt <= r_div3_cnt + {3'b000, f_div3(w_next)};
                     end else begin
                        r_led1  <= 1'b0;
                        r_led2  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                     end
                  end else begin
                     r_timer <= r_timer + 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign val      = r_val;
   assign led1     = r_led1;
   assign led2     = r_led2;
   assign busy     = r_busy;
   assign done     = r_done;
   assign even_cnt = r_even_cnt;
   assign div3_cnt = r_div3_cnt;

endmodule

`default_nettype wire

// File: tb/tb_div_scan_ctrl.sv
// ============================================================================
// Module   : tb_div_scan_ctrl
// Purpose  : Directed, table-driven bench for div_scan_ctrl (HOLD_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_scan_ctrl;

   localparam int H = 4;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       mode;
   logic [3:0] sw;
`ifdef DIV_SCAN_PAUSE_EN
   logic       pause;
`endif
   logic [3:0] val;
   logic       led1;
   logic       led2;
   logic       busy;
   logic       done;
   logic [3:0] even_cnt;
   logic [3:0] div3_cnt;

   div_scan_ctrl #(.HOLD_CYCLES(H)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .mode     (mode),
      .sw       (sw),
`ifdef DIV_SCAN_PAUSE_EN
      .pause    (pause),
`endif
      .val      (val),
      .led1     (led1),
      .led2     (led2),
      .busy     (busy),
      .done     (done),
      .even_cnt (even_cnt),
      .div3_cnt (div3_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] sw;
      logic       l1;
      logic       l2;
      logic [3:0] ec;
      logic [3:0] dc;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns the cycle index at which done is seen, or -1 if the bound expires.
   task automatic find_done(input int c0, input int limit, output int cyc);
      cyc = -1;
      for (int i = c0; i <= c0 + limit; i++) begin
         if (done) begin
            cyc = i;
            break;
         end
         tick();
      end
   endtask

   task automatic do_scan();
      start = 1'b1; mode = 1'b1; sw = 4'd7;
      tick();
      start = 1'b0; mode = 1'b0;
      for (int v = 1; v <= 15; v++) begin
         for (int c = 0; c < H; c++) begin
            chk("scan_val",  int'(val),  v);
            chk("scan_led1", int'(led1), (v % 2 == 0) ? 1 : 0);
            chk("scan_led2", int'(led2), (v % 3 == 0) ? 1 : 0);
            chk("scan_busy", int'(busy), 1);
            chk("scan_done", int'(done), 0);
            if (c == 0) begin
               chk("scan_even_cnt", int'(even_cnt), v / 2);
               chk("scan_div3_cnt", int'(div3_cnt), v / 3);
            end
            tick();
         end
      end
      chk("scan_done_pulse", int'(done), 1);
      chk("scan_end_busy",   int'(busy), 0);
      chk("scan_end_led1",   int'(led1), 0);
      chk("scan_end_led2",   int'(led2), 0);
      chk("scan_end_val",    int'(val), 15);
      chk("scan_end_even",   int'(even_cnt), 7);
      chk("scan_end_div3",   int'(div3_cnt), 5);
      tick();
      chk("scan_done_clear", int'(done), 0);
      chk("scan_idle_busy",  int'(busy), 0);
   endtask

   initial begin
      int dc;
      int n5;

      tbl[0] = '{4'd0,  1'b0, 1'b0, 4'd0, 4'd0};
      tbl[1] = '{4'd1,  1'b0, 1'b0, 4'd0, 4'd0};
      tbl[2] = '{4'd2,  1'b1, 1'b0, 4'd1, 4'd0};
      tbl[3] = '{4'd3,  1'b0, 1'b1, 4'd0, 4'd1};
      tbl[4] = '{4'd6,  1'b1, 1'b1, 4'd1, 4'd1};
      tbl[5] = '{4'd9,  1'b0, 1'b1, 4'd0, 4'd1};
      tbl[6] = '{4'd12, 1'b1, 1'b1, 4'd1, 4'd1};
      tbl[7] = '{4'd15, 1'b0, 1'b1, 4'd0, 4'd1};
      tbl[8] = '{4'd14, 1'b1, 1'b0, 4'd1, 4'd0};
      tbl[9] = '{4'd8,  1'b1, 1'b0, 4'd1, 4'd0};

      rst_n = 1'b1; start = 1'b0; mode = 1'b0; sw = 4'd0;
`ifdef DIV_SCAN_PAUSE_EN
      pause = 1'b0;
`endif
      #2 rst_n = 1'b0;
      tick();
      tick();
      chk("rst_val",  int'(val), 0);
      chk("rst_led1", int'(led1), 0);
      chk("rst_led2", int'(led2), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_even", int'(even_cnt), 0);
      chk("rst_div3", int'(div3_cnt), 0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      do_scan();

      // Single checks; sw and mode are scrambled right after acceptance.
      for (int k = 0; k < 10; k++) begin
         start = 1'b1; mode = 1'b0; sw = tbl[k].sw;
         tick();
         start = 1'b0; mode = 1'b1; sw = ~tbl[k].sw;
         for (int c = 1; c <= H; c++) begin
            chk("single_val",  int'(val), int'(tbl[k].sw));
            chk("single_led1", int'(led1), int'(tbl[k].l1));
            chk("single_led2", int'(led2), int'(tbl[k].l2));
            chk("single_busy", int'(busy), 1);
            chk("single_done", int'(done), 0);
            chk("single_even", int'(even_cnt), int'(tbl[k].ec));
            chk("single_div3", int'(div3_cnt), int'(tbl[k].dc));
            tick();
         end
         chk("single_done_pulse", int'(done), 1);
         chk("single_end_busy",   int'(busy), 0);
         chk("single_end_led1",   int'(led1), 0);
         chk("single_end_led2",   int'(led2), 0);
         chk("single_end_val",    int'(val), int'(tbl[k].sw));
         chk("single_end_even",   int'(even_cnt), int'(tbl[k].ec));
         chk("single_end_div3",   int'(div3_cnt), int'(tbl[k].dc));
         tick();
         chk("single_done_clear", int'(done), 0);
      end

      // start re-pulsed in SHOW and in DONE is ignored.
      start = 1'b1; mode = 1'b0; sw = 4'd6;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1; mode = 1'b1; sw = 4'd3;
      tick();
      start = 1'b0;
      chk("ign_show_val",  int'(val), 6);
      chk("ign_show_even", int'(even_cnt), 1);
      chk("ign_show_div3", int'(div3_cnt), 1);
      tick();
      tick();
      chk("ign_done_pulse", int'(done), 1);
      start = 1'b1; mode = 1'b1; sw = 4'd3;
      tick();
      start = 1'b0;
      chk("ign_done_busy", int'(busy), 0);
      tick();
      chk("ign_idle_busy", int'(busy), 0);
      chk("ign_idle_val",  int'(val), 6);
      chk("ign_idle_even", int'(even_cnt), 1);
      chk("ign_idle_div3", int'(div3_cnt), 1);

      // Held start relaunches as soon as IDLE is re-entered.
      start = 1'b1; mode = 1'b0; sw = 4'd2;
      tick();
      chk("held_val1", int'(val), 2);
      tick(); tick(); tick(); tick();
      chk("held_done", int'(done), 1);
      sw = 4'd4;
      tick();
      chk("held_idle_busy", int'(busy), 0);
      tick();
      start = 1'b0;
      chk("held_relaunch_busy", int'(busy), 1);
      chk("held_relaunch_val",  int'(val), 4);
      chk("held_relaunch_led1", int'(led1), 1);
      chk("held_relaunch_led2", int'(led2), 0);
      chk("held_relaunch_even", int'(even_cnt), 1);
      chk("held_relaunch_div3", int'(div3_cnt), 0);
      find_done(7, 20, dc);
      chk("held_done_cycle", dc, 11);
      tick();

      // Asynchronous reset mid-scan at val=9.
      start = 1'b1; mode = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i < 34; i++) tick();
      chk("abort_pre_val", int'(val), 9);
      rst_n = 1'b0;
      #1;
      chk("abort_val",  int'(val), 0);
      chk("abort_led1", int'(led1), 0);
      chk("abort_led2", int'(led2), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_even", int'(even_cnt), 0);
      chk("abort_div3", int'(div3_cnt), 0);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("abort_no_done", int'(done), 0);
         chk("abort_no_busy", int'(busy), 0);
      end
      do_scan();

`ifdef DIV_SCAN_PAUSE_EN
      // pause for 10 cycles while val=5.
      start = 1'b1; mode = 1'b1;
      tick();
      start = 1'b0;
      n5 = 0;
      dc = -1;
      for (int i = 1; i <= 200; i++) begin
         if (i == 18) pause = 1'b1;
         if (i == 28) pause = 1'b0;
         if (val == 4'd5) n5++;
         if (i == 31) chk("pause_val_after", int'(val), 6);
         if (done) begin
            dc = i;
            break;
         end
         tick();
      end
      chk("pause_val5_cycles", n5, 14);
      chk("pause_done_cycle", dc, 15 * H + 1 + 10);
      tick();
`else
      n5 = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
